// File: rtl/mem_req_if.sv
// Pipeline-side load/store adapter in front of mem_system: holds the request,
// returns a one-cycle response, checks alignment, runs a watchdog, keeps stats.
module mem_req_if #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        pipe_stall,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_datain,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_cachehit,
    input  logic        mem_err,
    input  logic        stat_clr,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_accesses
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]      SAT     = 16'hFFFF;

    state_t           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             rv_q, rv_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [15:0]      hits_q, hits_d;
    logic [15:0]      acc_q, acc_d;
    logic             inc_acc, inc_hit;
    logic             unused_stall;

    // Stall from mem_system is observed only; Done is the sole completion event.
    assign unused_stall = mem_stall;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        wdog_d  = wdog_q;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        inc_acc = 1'b0;
        inc_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_addr[0]) begin
                        state_d = ERR;
                        rv_d    = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = BUSY;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        wr_d    = req_wr;
                        wdog_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_done) begin
                    state_d = IDLE;
                    rv_d    = 1'b1;
                    err_d   = mem_err;
                    rdata_d = (wr_q || mem_err) ? 16'h0 : mem_dataout;
                    inc_acc = 1'b1;
                    inc_hit = mem_cachehit;
                end else if (mem_err || wdog_q == WD_LAST) begin
                    state_d = IDLE;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        hits_d = hits_q;
        if (stat_clr) begin
            acc_d  = '0;
            hits_d = '0;
        end else begin
            if (inc_acc && acc_q != SAT)  acc_d  = acc_q + 16'd1;
            if (inc_hit && hits_q != SAT) hits_d = hits_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            wdog_q  <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            hits_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            wdog_q  <= wdog_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            hits_q  <= hits_d;
            acc_q   <= acc_d;
        end
    end

    // Strobes decode straight from state so reset drops them without a clock.
    assign req_ready     = (state_q == IDLE);
    assign pipe_stall    = (state_q != IDLE);
    assign mem_rd        = (state_q == BUSY) && !wr_q;
    assign mem_wr        = (state_q == BUSY) && wr_q;
    assign mem_addr      = addr_q;
    assign mem_datain    = wdata_q;
    assign resp_valid    = rv_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign stat_hits     = hits_q;
    assign stat_accesses = acc_q;

endmodule
